// File: rtl/row_pack_mdl_if.sv
// rtl/row_pack_mdl_if.sv - serial element stream in, packed row and end-of-matrix strobes out
interface row_pack_mdl_if #(
    parameter int DATA_SIZE = 16,
    parameter int ROW_SIZE  = 64
);
    logic                          dinValid;
    logic [DATA_SIZE-1:0]          din;
    logic                          dinLast;
    logic                          dinReady;
    logic [DATA_SIZE*ROW_SIZE-1:0] dats;
    logic                          datsValid;
    logic                          dendFlag;

    modport master (
        output dinValid, din, dinLast,
        input  dinReady, dats, datsValid, dendFlag
    );

    modport slave (
        input  dinValid, din, dinLast,
        output dinReady, dats, datsValid, dendFlag
    );
endinterface

// File: rtl/row_pack_mdl.sv
// rtl/row_pack_mdl.sv - packs ROW_SIZE serial words into a row and flags end of matrix
module row_pack_mdl #(
    parameter int DATA_SIZE   = 16,
    parameter int ROW_SIZE    = 64,
    parameter int COLUMN_SIZE = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    row_pack_mdl_if.slave               bus,
    output logic [$clog2(COLUMN_SIZE):0] rowCount,
    output logic                        overrun
);
    localparam int EW = $clog2(ROW_SIZE) + 1;
    localparam int RW = $clog2(COLUMN_SIZE) + 1;
    localparam int PW = DATA_SIZE * ROW_SIZE;

    typedef enum logic [1:0] {FILL, EMIT, ENDM} state_t;

    state_t          state, state_nxt;
    logic [EW-1:0]   elem_cnt;
    logic [RW-1:0]   row_cnt;
    logic [PW-1:0]   pack, pack_nxt;
    logic [PW-1:0]   dats_q;
    logic            last_seen;
    logic            accept;
    logic            din_ready;
    logic            dats_valid;
    logic            dend_flag;

    always_comb begin
        pack_nxt = pack;
        for (int k = 0; k < ROW_SIZE; k++) begin
            if (elem_cnt == EW'(k)) begin
                pack_nxt[k*DATA_SIZE +: DATA_SIZE] = bus.din;
            end
        end
    end

    // Strobes are combinational on the state so a stalled EMIT/END fires as soon as enable returns.
    always_comb begin
        state_nxt  = state;
        din_ready  = 1'b0;
        dats_valid = 1'b0;
        dend_flag  = 1'b0;
        accept     = 1'b0;
        if (enable) begin
            case (state)
                FILL: begin
                    din_ready = 1'b1;
                    if (bus.dinValid) begin
                        accept = 1'b1;
                        if (elem_cnt == EW'(ROW_SIZE - 1) || bus.dinLast) begin
                            state_nxt = EMIT;
                        end
                    end
                end
                EMIT: begin
                    dats_valid = 1'b1;
                    if (last_seen || row_cnt == RW'(COLUMN_SIZE - 1)) begin
                        state_nxt = ENDM;
                    end else begin
                        state_nxt = FILL;
                    end
                end
                ENDM: begin
                    dend_flag = 1'b1;
                    state_nxt = FILL;
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            elem_cnt  <= '0;
            row_cnt   <= '0;
            pack      <= '0;
            dats_q    <= '0;
            last_seen <= 1'b0;
            overrun   <= 1'b0;
        end else if (enable) begin
            state <= state_nxt;
            if (bus.dinValid && !din_ready) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                pack      <= pack_nxt;
                elem_cnt  <= elem_cnt + EW'(1);
                last_seen <= bus.dinLast;
                // Row is latched on entry to EMIT so dats is valid during the strobe cycle.
                if (state_nxt == EMIT) begin
                    dats_q <= pack_nxt;
                end
            end
            if (state == EMIT) begin
                pack     <= '0;
                elem_cnt <= '0;
                row_cnt  <= row_cnt + RW'(1);
            end
            if (state == ENDM) begin
                row_cnt   <= '0;
                last_seen <= 1'b0;
            end
        end
    end

    assign bus.dinReady  = din_ready;
    assign bus.dats      = dats_q;
    assign bus.datsValid = dats_valid;
    assign bus.dendFlag  = dend_flag;
    assign rowCount      = row_cnt;
endmodule

// File: tb/tb_row_pack_mdl.sv
// tb/tb_row_pack_mdl.sv - table-driven scoreboard bench for row_pack_mdl
module tb_row_pack_mdl;
    localparam int DS = 8;
    localparam int RS = 4;
    localparam int CS = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] rowCount;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int ends = 0;
    bit pend_end = 0;

    typedef struct {
        logic [31:0] dats;
        bit          dend;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          n;
        logic [7:0]  w[4];
        bit          last;
        logic [31:0] exp_dats;
        bit          exp_end;
        logic [2:0]  exp_rc;
    } vec_t;
    vec_t tbl[6];

    row_pack_mdl_if #(.DATA_SIZE(DS), .ROW_SIZE(RS)) bus ();

    row_pack_mdl #(.DATA_SIZE(DS), .ROW_SIZE(RS), .COLUMN_SIZE(CS)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus.slave),
        .rowCount (rowCount),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (pend_end) begin
            chk("dend_pulse", {31'd0, bus.dendFlag}, 32'd1);
            pend_end = 0;
        end else if (bus.dendFlag) begin
            tests++;
            fails++;
            $display("FAIL unexpected_dend: got dendFlag=1, required 0");
        end
        if (bus.dendFlag) ends++;
        if (bus.datsValid) begin
            pulses++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_row: got dats=%h, required no pulse", bus.dats);
            end else begin
                e = sb.pop_front();
                chk("dats", bus.dats, e.dats);
                pend_end = e.dend;
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit last);
        int guard = 0;
        @(negedge clock);
        while (!bus.dinReady && guard < 50) begin
            bus.dinValid = 1'b0;
            guard++;
            @(negedge clock);
        end
        if (!bus.dinReady) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got dinReady=0, required 1");
        end else begin
            bus.dinValid = 1'b1;
            bus.din      = d;
            bus.dinLast  = last;
            @(posedge clock);
        end
    endtask

    task automatic idle_settle();
        @(negedge clock);
        bus.dinValid = 1'b0;
        bus.dinLast  = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic set_vec(input int i, input int n, input logic [31:0] w, input bit last,
                           input logic [31:0] ed, input bit ee, input logic [2:0] rc);
        tbl[i].n        = n;
        tbl[i].w[0]     = w[7:0];
        tbl[i].w[1]     = w[15:8];
        tbl[i].w[2]     = w[23:16];
        tbl[i].w[3]     = w[31:24];
        tbl[i].last     = last;
        tbl[i].exp_dats = ed;
        tbl[i].exp_end  = ee;
        tbl[i].exp_rc   = rc;
    endtask

    initial begin
        int p0, e0;
        set_vec(0, 4, 32'h04030201, 0, 32'h04030201, 0, 3'd1);
        set_vec(1, 4, 32'h08070605, 0, 32'h08070605, 0, 3'd2);
        set_vec(2, 4, 32'h0C0B0A09, 0, 32'h0C0B0A09, 1, 3'd0);
        set_vec(3, 2, 32'h00002211, 1, 32'h00002211, 1, 3'd0);
        set_vec(4, 4, 32'h34333231, 0, 32'h34333231, 0, 3'd1);
        set_vec(5, 4, 32'h44434241, 1, 32'h44434241, 1, 3'd0);

        reset = 1'b0;
        enable = 1'b0;
        bus.dinValid = 1'b0;
        bus.din = '0;
        bus.dinLast = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_dats", bus.dats, 32'd0);
        chk("rst_datsValid", {31'd0, bus.datsValid}, 32'd0);
        chk("rst_dendFlag", {31'd0, bus.dendFlag}, 32'd0);
        chk("rst_rowCount", {29'd0, rowCount}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_dinReady", {31'd0, bus.dinReady}, 32'd0);
        reset = 1'b1;
        enable = 1'b1;

        for (int i = 0; i < 6; i++) begin
            p0 = pulses;
            e0 = ends;
            sb.push_back('{dats: tbl[i].exp_dats, dend: tbl[i].exp_end});
            for (int k = 0; k < tbl[i].n; k++) begin
                send(tbl[i].w[k], tbl[i].last && (k == tbl[i].n - 1));
            end
            idle_settle();
            chk("vec_pulses", pulses - p0, 1);
            chk("vec_ends", ends - e0, {31'd0, tbl[i].exp_end});
            chk("vec_rowCount", {29'd0, rowCount}, {29'd0, tbl[i].exp_rc});
        end
        chk("no_overrun_yet", {31'd0, overrun}, 32'd0);

        // Stall with the EMIT pending.
        p0 = pulses;
        sb.push_back('{dats: 32'h04030201, dend: 0});
        for (int k = 1; k <= 4; k++) send(8'(k), 0);
        #1;
        enable = 1'b0;
        bus.dinValid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("stall_dinReady", {31'd0, bus.dinReady}, 32'd0);
            chk("stall_datsValid", {31'd0, bus.datsValid}, 32'd0);
        end
        @(posedge clock);
        #1;
        enable = 1'b1;
        @(negedge clock);
        chk("stall_release_pulse", {31'd0, bus.datsValid}, 32'd1);
        repeat (2) @(negedge clock);
        chk("stall_pulses", pulses - p0, 1);
        chk("stall_rowCount", {29'd0, rowCount}, 32'd1);

        // Word offered during EMIT is dropped; the third row also hits the row limit.
        p0 = pulses;
        e0 = ends;
        sb.push_back('{dats: 32'h64636261, dend: 0});
        sb.push_back('{dats: 32'h74737271, dend: 1});
        for (int k = 1; k <= 4; k++) send(8'(8'h60 + k), 0);
        #1;
        bus.din = 8'hEE;
        bus.dinValid = 1'b1;
        bus.dinLast = 1'b0;
        @(posedge clock);
        #1;
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        for (int k = 1; k <= 4; k++) send(8'(8'h70 + k), 0);
        idle_settle();
        chk("bp_pulses", pulses - p0, 2);
        chk("bp_ends", ends - e0, 1);
        chk("bp_rowCount", {29'd0, rowCount}, 32'd0);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of a row.
        p0 = pulses;
        send(8'h55, 0);
        send(8'h66, 0);
        @(negedge clock);
        bus.dinValid = 1'b0;
        enable = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_dats", bus.dats, 32'd0);
        chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        chk("mid_rst_rowCount", {29'd0, rowCount}, 32'd0);
        chk("mid_rst_datsValid", {31'd0, bus.datsValid}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        enable = 1'b1;
        chk("mid_rst_no_pulse", pulses - p0, 0);
        sb.push_back('{dats: 32'hA4A3A2A1, dend: 0});
        for (int k = 1; k <= 4; k++) send(8'(8'hA0 + k), 0);
        idle_settle();
        chk("post_rst_pulses", pulses - p0, 1);
        chk("post_rst_rowCount", {29'd0, rowCount}, 32'd1);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end
endmodule
